// File: rtl/ext_ins_pkg.sv
// Shared types and constants for the external instruction fetch responder.
//   state_e     : responder FSM states (idle, latency wait, response pulse)
//   NOP_INST    : RV32I NOP (addi x0,x0,0), default word returned on a bad fetch
//   LATENCY_MAX : largest supported request-to-valid latency
//   CNT_W       : width of the latency counter
package ext_ins_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   localparam logic [31:0] NOP_INST    = 32'h0000_0013;
   localparam int unsigned LATENCY_MAX = 15;
   localparam int unsigned CNT_W       = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/ins_store_ram.sv
// Instruction store: 1R1W synchronous word RAM.
// A read and a write to the same word on one edge return the OLD word; the
// write still lands. Contents are never reset; only the read register is.
// The array is named mem so benches can preload it hierarchically.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset (clears the read register)
//   re_i    : read enable, raddr_i sampled on the rising edge
//   raddr_i : read word index
//   rdata_o : registered read data, holds while re_i is low
//   we_i    : write enable
//   waddr_i : write word index
//   wdata_i : write data
module ins_store_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   // Non-blocking update, so a same-edge read still sees the previous word.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_ins_responder.sv
// Responder end of the core's external instruction fetch interface.
// Accepts a fetch in idle, waits LATENCY cycles (counted from the cycle the
// request is first seen) and pulses exIns_valid for one cycle with the word
// from the local store, or with FILL_INST/exIns_err on a bad address.
//   clk, rst    : clock (rising edge) and asynchronous active-high reset
//   exIns_ren   : fetch request, held by the core until exIns_valid
//   exIns_addr  : fetch byte address
//   exIns_valid : one-cycle response pulse
//   exIns_in    : fetched word, holds the last returned word between pulses
//   exIns_err   : with exIns_valid, misaligned or out-of-range address
//   ld_we/ld_addr/ld_data : side load port into the store, any state
//   busy        : fetch in progress (wait or response)
module ext_ins_responder
   import ext_ins_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] FILL_INST = NOP_INST
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     exIns_ren,
   input  logic [31:0]              exIns_addr,
   output logic                     exIns_valid,
   output logic [31:0]              exIns_in,
   output logic                     exIns_err,
   input  logic                     ld_we,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [31:0]              ld_data,
   output logic                     busy
);

   localparam int unsigned   AW     = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LatM1 = CNT_W'(LATENCY - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic             err_q, err_d;

   logic [31:0]      off;
   logic             dec_err;
   logic             rd_en;
   logic [31:0]      rd_data;

   // Decode straight from the bus: on the completing edge the bus address
   // always equals the latched one (a mismatch restarts instead).
   assign off     = exIns_addr - BASE_ADDR;
   assign dec_err = (exIns_addr[1:0] != 2'b00) || ((off >> 2) >= DEPTH);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      err_d   = err_q;
      rd_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (exIns_ren) begin
               addr_d = exIns_addr;
               if (LATENCY == 1) begin
                  state_d = StResp;
                  cnt_d   = '0;
                  err_d   = dec_err;
                  rd_en   = !dec_err;
               end else begin
                  state_d = StWait;
                  cnt_d   = LatM1;
               end
            end
         end
         StWait: begin
            if (!exIns_ren) begin
               // Core flushed the fetch: drop it silently.
               state_d = StIdle;
               cnt_d   = '0;
            end else if (exIns_addr != addr_q) begin
               // New address while waiting: restart the full latency.
               addr_d = exIns_addr;
               cnt_d  = LatM1;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = StResp;
               cnt_d   = '0;
               err_d   = dec_err;
               rd_en   = !dec_err;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   ins_store_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_store (
      .clk_i   (clk),
      .rst_i   (rst),
      .re_i    (rd_en),
      .raddr_i (off[AW+1:2]),
      .rdata_o (rd_data),
      .we_i    (ld_we),
      .waddr_i (ld_addr),
      .wdata_i (ld_data)
   );

   assign exIns_valid = (state_q == StResp);
   assign exIns_err   = exIns_valid && err_q;
   // Both sources hold between responses, so the last word stays visible.
   assign exIns_in    = err_q ? FILL_INST : rd_data;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ext_ins_responder.sv
// Self-checking bench for ext_ins_responder with a behavioural fetch model.
module tb_ext_ins_responder;

   localparam int unsigned DEPTH   = 256;
   localparam int unsigned LATENCY = 2;
   localparam logic [31:0] BASE    = 32'h0000_0000;
   localparam logic [31:0] FILL    = 32'h0000_0013;
   localparam int          TMO     = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        exIns_ren;
   logic [31:0] exIns_addr;
   logic        exIns_valid;
   logic [31:0] exIns_in;
   logic        exIns_err;
   logic        ld_we;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [31:0] mem_model [DEPTH];

   ext_ins_responder #(
      .DEPTH     (DEPTH),
      .LATENCY   (LATENCY),
      .BASE_ADDR (BASE),
      .FILL_INST (FILL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .exIns_ren   (exIns_ren),
      .exIns_addr  (exIns_addr),
      .exIns_valid (exIns_valid),
      .exIns_in    (exIns_in),
      .exIns_err   (exIns_err),
      .ld_we       (ld_we),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: {err, word} for a byte address.
   function automatic logic [32:0] model_fetch(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      if ((a % 4) != 0 || (o / 4) >= DEPTH) return {1'b1, FILL};
      return {1'b0, mem_model[o / 4]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ld_write(input int idx, input logic [31:0] d);
      ld_we = 1'b1;
      ld_addr = 8'(idx);
      ld_data = d;
      step();
      ld_we = 1'b0;
      mem_model[idx] = d;
   endtask

   // Issue one fetch from idle; returns cycles to valid, data and err, then
   // leaves one idle cycle so the next call starts in idle again.
   task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] d,
                           output logic e);
      exIns_ren = 1'b1;
      exIns_addr = a;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!exIns_valid && lat < TMO);
      d = exIns_in;
      e = exIns_err;
      exIns_ren = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      exIns_ren = 1'b0;
      exIns_addr = '0;
      ld_we = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      step();
      step();
      checks++;
      if (exIns_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", exIns_valid);
      end
      checks++;
      if (exIns_err !== 1'b0) begin
         errors++; $display("FAIL reset_err: got %b expected 0", exIns_err);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (exIns_in !== 32'h0) begin
         errors++; $display("FAIL reset_data: got %h expected 00000000", exIns_in);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int lat;
      logic [31:0] d;
      logic e;
      ld_write(4, 32'h0050_0093);
      exIns_ren = 1'b1;
      exIns_addr = 32'h10;
      step();
      checks++;
      if (busy !== 1'b1 || exIns_valid !== 1'b0) begin
         errors++; $display("FAIL basic_wait: got busy=%b valid=%b expected busy=1 valid=0",
                            busy, exIns_valid);
      end
      lat = 1;
      while (!exIns_valid && lat < TMO) begin
         step();
         lat++;
      end
      d = exIns_in;
      e = exIns_err;
      checks++;
      if (lat != LATENCY) begin
         errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LATENCY);
      end
      checks++;
      if (d !== 32'h0050_0093 || e !== 1'b0) begin
         errors++; $display("FAIL basic_data: got %h err=%b expected 00500093 err=0", d, e);
      end
      step();
      checks++;
      if (exIns_valid !== 1'b0 || exIns_in !== 32'h0050_0093) begin
         errors++; $display("FAIL basic_pulse: got valid=%b data=%h expected valid=0 data=00500093",
                            exIns_valid, exIns_in);
      end
      exIns_ren = 1'b0;
      step();
   endtask

   task automatic test_reset_midrun();
      int n;
      exIns_ren = 1'b1;
      exIns_addr = 32'h10;
      step();
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || exIns_valid !== 1'b0) begin
         errors++; $display("FAIL reset_wait: got busy=%b valid=%b expected 0 0", busy, exIns_valid);
      end
      exIns_ren = 1'b0;
      rst = 1'b0;
      step();
      exIns_ren = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!exIns_valid && n < TMO);
      checks++;
      if (exIns_valid !== 1'b1 || exIns_in !== mem_model[4]) begin
         errors++; $display("FAIL reset_pre_resp: got valid=%b data=%h expected 1 %h",
                            exIns_valid, exIns_in, mem_model[4]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (exIns_valid !== 1'b0 || exIns_in !== 32'h0 || exIns_err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_resp: got valid=%b data=%h err=%b busy=%b expected all 0",
                            exIns_valid, exIns_in, exIns_err, busy);
      end
      exIns_ren = 1'b0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [$];
      logic [32:0] exp;
      int prev;
      int n;
      addrs = '{32'h0, 32'h4, 32'h8};
      for (int i = 0; i < 12; i++) addrs.push_back($urandom_range(DEPTH - 1, 0) * 4);
      prev = 0;
      exIns_ren = 1'b1;
      for (int i = 0; i < addrs.size(); i++) begin
         // Set during the previous response cycle, which the DUT ignores.
         exIns_addr = addrs[i];
         exp = model_fetch(addrs[i]);
         n = 0;
         do begin
            step();
            n++;
         end while (!exIns_valid && n < TMO);
         checks++;
         if (exIns_valid !== 1'b1 || exIns_in !== exp[31:0] || exIns_err !== exp[32]) begin
            errors++; $display("FAIL b2b_data[%0d]: got valid=%b %h err=%b expected 1 %h err=%b",
                               i, exIns_valid, exIns_in, exIns_err, exp[31:0], exp[32]);
         end
         if (i > 0) begin
            checks++;
            if (cyc - prev != LATENCY + 1) begin
               errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d",
                                  i, cyc - prev, LATENCY + 1);
            end
         end
         prev = cyc;
      end
      exIns_ren = 1'b0;
      step();
   endtask

   task automatic test_abort_restart();
      int seen;
      int n;
      exIns_ren = 1'b1;
      exIns_addr = 32'h14;
      step();
      exIns_ren = 1'b0;
      seen = 0;
      repeat (6) begin
         step();
         if (exIns_valid) seen++;
      end
      checks++;
      if (seen != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort: got pulses=%0d busy=%b expected 0 0", seen, busy);
      end
      exIns_ren = 1'b1;
      exIns_addr = 32'h0;
      step();
      exIns_addr = 32'h20;
      n = 0;
      do begin
         step();
         n++;
      end while (!exIns_valid && n < TMO);
      checks++;
      if (n != LATENCY) begin
         errors++; $display("FAIL restart_latency: got %0d expected %0d", n, LATENCY);
      end
      checks++;
      if (exIns_in !== mem_model[8] || exIns_err !== 1'b0) begin
         errors++; $display("FAIL restart_data: got %h err=%b expected %h err=0",
                            exIns_in, exIns_err, mem_model[8]);
      end
      exIns_ren = 1'b0;
      step();
   endtask

   task automatic test_errors();
      logic [31:0] addrs [$];
      logic [32:0] exp;
      int lat;
      logic [31:0] d;
      logic e;
      addrs = '{32'h402, 32'h400, 32'h3FC, 32'h1};
      for (int i = 0; i < 6; i++) addrs.push_back($urandom);
      foreach (addrs[i]) begin
         exp = model_fetch(addrs[i]);
         do_fetch(addrs[i], lat, d, e);
         checks++;
         if (lat != LATENCY || d !== exp[31:0] || e !== exp[32]) begin
            errors++; $display("FAIL err_addr %h: got lat=%0d %h err=%b expected lat=%0d %h err=%b",
                               addrs[i], lat, d, e, LATENCY, exp[31:0], exp[32]);
         end
      end
   endtask

   task automatic test_read_before_write();
      int lat;
      logic [31:0] d;
      logic e;
      logic [31:0] old;
      ld_write(3, 32'h1234_5678);
      old = mem_model[3];
      exIns_ren = 1'b1;
      exIns_addr = 32'hC;
      repeat (LATENCY - 1) step();
      // Write lands on the same edge the store is read.
      ld_we = 1'b1;
      ld_addr = 8'd3;
      ld_data = 32'hdead_beef;
      step();
      ld_we = 1'b0;
      mem_model[3] = 32'hdead_beef;
      checks++;
      if (exIns_valid !== 1'b1 || exIns_in !== old) begin
         errors++; $display("FAIL rbw_old: got valid=%b %h expected 1 %h", exIns_valid, exIns_in, old);
      end
      exIns_ren = 1'b0;
      step();
      do_fetch(32'hC, lat, d, e);
      checks++;
      if (d !== 32'hdead_beef || e !== 1'b0 || lat != LATENCY) begin
         errors++; $display("FAIL rbw_new: got %h err=%b lat=%0d expected deadbeef err=0 lat=%0d",
                            d, e, lat, LATENCY);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [32:0] exp;
      int lat;
      logic [31:0] d;
      logic e;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(3, 0) == 0) ld_write($urandom_range(DEPTH - 1, 0), $urandom);
         if ($urandom_range(9, 0) < 7) a = $urandom_range(DEPTH - 1, 0) * 4;
         else a = $urandom;
         exp = model_fetch(a);
         do_fetch(a, lat, d, e);
         checks++;
         if (lat != LATENCY || d !== exp[31:0] || e !== exp[32]) begin
            errors++; $display("FAIL rand[%0d] addr %h: got lat=%0d %h err=%b expected lat=%0d %h err=%b",
                               i, a, lat, d, e, LATENCY, exp[31:0], exp[32]);
         end
      end
   endtask

   initial begin
      test_reset();
      for (int i = 0; i < DEPTH; i++) ld_write(i, $urandom);
      test_basic();
      test_reset_midrun();
      test_back_to_back();
      test_abort_restart();
      test_errors();
      test_read_before_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
